// File: rtl/stream_rr_arb.sv
// stream_rr_arb: N-input round-robin stream arbiter with packet locking.
// A winner is chosen round-robin while idle. The grant stays with that
// requester until its last beat, and gaps inside a packet keep the grant.
// The output stage is a single register slice that can drain and load in
// the same cycle, so it sustains one beat per cycle.
module stream_rr_arb #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N*DW-1:0]      in_data_i,
  input  logic [N-1:0]         in_valid_i,
  input  logic [N-1:0]         in_last_i,
  output logic [N-1:0]         in_ready_o,
  output logic [DW-1:0]        out_data_o,
  output logic                 out_valid_o,
  output logic                 out_last_o,
  output logic [$clog2(N)-1:0] out_src_o,
  input  logic                 out_ready_i
);

  localparam int SW = $clog2(N);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   owner_q, owner_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic            out_valid_q, out_valid_d;
  logic [SW-1:0]   out_src_q, out_src_d;

  logic [DW-1:0]   lane_data_s [N];
  logic            win_found_s;
  logic [SW-1:0]   win_idx_s;
  logic            free_s;
  logic [N-1:0]    ready_s;
  logic [SW-1:0]   sel_s;
  logic            sel_last_s;
  logic            accept_s;

  // Split the flat data bus into one lane per requester.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      lane_data_s[i] = in_data_i[i*DW +: DW];
    end
  end

  // Round-robin search: first valid requester starting at ptr, wrapping mod N.
  always_comb begin
    logic [SW:0] raw;
    logic [SW:0] cand;
    logic        hit;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    raw         = '0;
    cand        = '0;
    hit         = 1'b0;
    for (int k = 0; k < N; k++) begin
      raw         = {1'b0, ptr_q} + (SW+1)'(k);
      cand        = (raw >= (SW+1)'(N)) ? (raw - (SW+1)'(N)) : raw;
      hit         = ~win_found_s & in_valid_i[cand[SW-1:0]];
      win_idx_s   = hit ? cand[SW-1:0] : win_idx_s;
      win_found_s = win_found_s | hit;
    end
  end

  // Grant selection: the round-robin winner when idle, the lock owner when locked.
  always_comb begin
    free_s  = ~out_valid_q | out_ready_i;
    ready_s = '0;
    sel_s   = '0;
    case (state_q)
      IDLE: begin
        sel_s = win_idx_s;
        if (win_found_s && free_s) begin
          ready_s[win_idx_s] = 1'b1;
        end else begin
          ready_s = '0;
        end
      end
      LOCKED: begin
        sel_s            = owner_q;
        ready_s[owner_q] = free_s;
      end
      default: begin
        sel_s   = '0;
        ready_s = '0;
      end
    endcase
    accept_s   = |(in_valid_i & ready_s);
    sel_last_s = in_last_i[sel_s];
  end

  // Ready drops as soon as reset asserts, without waiting for a clock edge.
  assign in_ready_o = rst_ni ? ready_s : '0;

  // Next state for the arbitration FSM and the output register slice.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    if (accept_s) begin
      out_data_d  = lane_data_s[sel_s];
      out_last_d  = sel_last_s;
      out_src_d   = sel_s;
      out_valid_d = 1'b1;
      if (sel_last_s) begin
        state_d = IDLE;
        ptr_d   = (sel_s == SW'(N-1)) ? '0 : (sel_s + SW'(1));
      end else begin
        state_d = LOCKED;
        owner_d = sel_s;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_src_o   = out_src_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_stream_rr_arb.sv
// tb_stream_rr_arb: cycle-level reference model plus a scoreboard of
// accepted beats, checked against the arbiter's handshakes and output.
module tb_stream_rr_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int DEPTH = 64;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [N*DW-1:0]   in_data_i;
  logic [N-1:0]      in_valid_i;
  logic [N-1:0]      in_last_i;
  logic [N-1:0]      in_ready_o;
  logic [DW-1:0]     out_data_o;
  logic              out_valid_o;
  logic              out_last_o;
  logic [SW-1:0]     out_src_o;
  logic              out_ready_i;

  stream_rr_arb #(.N(N), .DW(DW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_last_i   (in_last_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_last_o  (out_last_o),
    .out_src_o   (out_src_o),
    .out_ready_i (out_ready_i)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            src_log[$];
  int            exp_ord[$];
  logic [DW-1:0] bd [N][DEPTH];
  logic          bl [N][DEPTH];
  int            wr_i[N], rd_i[N], gap_at[N], gap_len[N];
  int            stall_cnt;
  bit            rand_rdy;
  bit            m_lock, m_ov;
  int            m_ptr, m_owner;
  int            n_tests, n_fail;
  int            ncyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit gapped(input int i);
    return (gap_len[i] > 0) && (rd_i[i] == gap_at[i]) && (rd_i[i] < wr_i[i]);
  endfunction

  task automatic add_beat(input int i, input logic [DW-1:0] d, input logic l);
    bd[i][wr_i[i]] = d;
    bl[i][wr_i[i]] = l;
    wr_i[i]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      wr_i[i] = 0; rd_i[i] = 0; gap_at[i] = 0; gap_len[i] = 0;
    end
    src_log.delete();
  endtask

  task automatic model_reset();
    m_lock = 1'b0; m_ov = 1'b0; m_ptr = 0; m_owner = 0;
    exp_q.delete();
    stall_cnt = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid_i[i] = (rd_i[i] < wr_i[i]) && !gapped(i);
      in_data_i[i*DW +: DW] = in_valid_i[i] ? bd[i][rd_i[i]] : 32'h0;
      in_last_i[i] = in_valid_i[i] ? bl[i][rd_i[i]] : 1'b0;
    end
    if (stall_cnt > 0) out_ready_i = 1'b0;
    else if (rand_rdy) out_ready_i = ($urandom_range(3) != 0);
    else out_ready_i = 1'b1;
  endtask

  // One clock: predict handshakes, check at the falling edge, advance the model.
  task automatic cycle();
    logic [N-1:0] m_rdy;
    logic [N-1:0] gmask;
    bit    free, acc;
    int    w, c, ai;
    beat_t b;
    free  = !m_ov || out_ready_i;
    m_rdy = '0;
    w     = -1;
    for (int i = 0; i < N; i++) gmask[i] = gapped(i);
    if (m_lock) begin
      m_rdy[m_owner] = free;
      ai = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (w < 0 && in_valid_i[c]) w = c;
      end
      if (w >= 0 && free) m_rdy[w] = 1'b1;
      ai = w;
    end
    acc = |(m_rdy & in_valid_i);
    @(negedge clk_i);
    chk("in_ready", in_ready_o, m_rdy);
    chk("out_valid", out_valid_o, m_ov);
    if (m_ov) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        b = exp_q[0];
        chk("out_src", out_src_o, b.src);
        chk("out_data", out_data_o, b.data);
        chk("out_last", out_last_o, b.last);
        if (out_ready_i) begin
          void'(exp_q.pop_front());
          src_log.push_back(int'(b.src));
        end
      end
    end
    if (acc) begin
      b.src  = SW'(ai);
      b.data = bd[ai][rd_i[ai]];
      b.last = bl[ai][rd_i[ai]];
      exp_q.push_back(b);
      rd_i[ai]++;
      if (b.last) begin
        m_lock = 1'b0;
        m_ptr  = (ai + 1) % N;
      end else begin
        m_lock  = 1'b1;
        m_owner = ai;
      end
    end
    m_ov = acc || (m_ov && !out_ready_i);
    for (int i = 0; i < N; i++) if (gmask[i]) gap_len[i]--;
    if (stall_cnt > 0) stall_cnt--;
    @(posedge clk_i);
    #1;
    drive();
  endtask

  function automatic bit busy();
    bit r;
    r = m_ov || (exp_q.size() != 0);
    for (int i = 0; i < N; i++) if (rd_i[i] < wr_i[i]) r = 1'b1;
    return r;
  endfunction

  task automatic run(input int max, output int cycles);
    cycles = 0;
    while (busy() && cycles < max) begin
      cycle();
      cycles++;
    end
    if (cycles >= max) chk("timeout", 64'd1, 64'd0);
    chk("drained", exp_q.size(), 64'd0);
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_len"}, src_log.size(), exp_ord.size());
    for (int k = 0; k < exp_ord.size() && k < src_log.size(); k++) begin
      chk(tag, src_log[k], exp_ord[k]);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed scenarios followed by a randomized soak.
  initial begin
    n_tests = 0; n_fail = 0; rand_rdy = 1'b0;
    clear_src();
    model_reset();
    in_valid_i  = '1;
    in_last_i   = '1;
    in_data_i   = '1;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", out_valid_o, 64'd0);
    chk("rst_data", out_data_o, 64'd0);
    chk("rst_last", out_last_o, 64'd0);
    chk("rst_src", out_src_o, 64'd0);
    chk("rst_ready", in_ready_o, 64'd0);
    drive();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Round-robin over single-beat packets at full rate.
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) add_beat(i, {8'(i), 8'h30, 16'(r)}, 1'b1);
    drive();
    run(200, ncyc);
    chk("tput030", ncyc, 64'd13);
    exp_ord.delete();
    for (int k = 0; k < 12; k++) exp_ord.push_back(k % N);
    check_order("ord030");

    // Lock: req 2 packet of 3 while req 0 waits (ptr moved to 2 first).
    clear_src();
    add_beat(1, 32'h3100_0001, 1'b1);
    drive();
    run(50, ncyc);
    clear_src();
    add_beat(2, 32'h3102_0000, 1'b0);
    add_beat(2, 32'h3102_0001, 1'b0);
    add_beat(2, 32'h3102_0002, 1'b1);
    add_beat(0, 32'h3100_0000, 1'b1);
    add_beat(0, 32'h3100_0010, 1'b1);
    drive();
    run(100, ncyc);
    exp_ord = '{2, 2, 2, 0, 0};
    check_order("ord031");

    // Backpressure: DEADBEEF held for 5 stalled cycles.
    clear_src();
    add_beat(3, 32'hDEADBEEF, 1'b1);
    stall_cnt = 6;
    drive();
    cycle();
    for (int i = 0; i < 3; i++) add_beat(i, {8'(i), 24'h320000}, 1'b1);
    drive();
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("hold032", out_data_o, 64'hDEADBEEF);
    end
    run(100, ncyc);
    chk("tput032", ncyc, 64'd4);
    exp_ord = '{3, 0, 1, 2};
    check_order("ord032");

    // Wrap search from ptr=3, then ptr must be 2.
    clear_src();
    add_beat(1, 32'h3301_0000, 1'b1);
    drive();
    run(50, ncyc);
    exp_ord = '{1};
    check_order("ord033a");
    clear_src();
    add_beat(0, 32'h3300_0000, 1'b1);
    add_beat(2, 32'h3302_0000, 1'b1);
    add_beat(3, 32'h3303_0000, 1'b1);
    drive();
    run(50, ncyc);
    exp_ord = '{2, 3, 0};
    check_order("ord033b");

    // Owner (req 1) gaps for 2 cycles mid-packet; req 3 must wait.
    clear_src();
    add_beat(1, 32'h3401_0000, 1'b0);
    add_beat(1, 32'h3401_0001, 1'b0);
    add_beat(1, 32'h3401_0002, 1'b1);
    add_beat(3, 32'h3403_0000, 1'b1);
    add_beat(3, 32'h3403_0001, 1'b1);
    gap_at[1]  = 1;
    gap_len[1] = 2;
    drive();
    run(100, ncyc);
    exp_ord = '{1, 1, 1, 3, 3};
    check_order("ord034");

    // Randomized packets, gaps and backpressure.
    clear_src();
    rand_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 30; k++)
        add_beat(i, $urandom(), (k == 29) ? 1'b1 : ($urandom_range(2) == 0));
      gap_at[i]  = $urandom_range(29);
      gap_len[i] = $urandom_range(3);
    end
    drive();
    run(3000, ncyc);
    rand_rdy = 1'b0;

    // Reset mid-packet with a buffered beat.
    clear_src();
    add_beat(2, 32'h3502_0000, 1'b0);
    add_beat(2, 32'h3502_0001, 1'b0);
    stall_cnt = 10;
    drive();
    cycle();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", out_valid_o, 64'd0);
    chk("arst_ready", in_ready_o, 64'd0);
    chk("arst_data", out_data_o, 64'd0);
    model_reset();
    clear_src();
    drive();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < N; i++) add_beat(i, {8'(i), 24'h350100}, 1'b1);
    drive();
    run(50, ncyc);
    exp_ord = '{0, 1, 2, 3};
    check_order("ord035");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_rr_arb.md
STREAM_RR_ARB -- requirements
Module: stream_rr_arb

Interface
REQ-001 Parameter N, default 4: number of requester streams, 2..16.
REQ-002 Parameter DW, default 32: data width of every stream.
REQ-003 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_data_i, input, N*DW: requester data; slice i = bits [i*DW +: DW].
REQ-006 Port in_valid_i, input, N: requester i presents a beat.
REQ-007 Port in_last_i, input, N: beat from requester i ends a packet.
REQ-008 Port in_ready_o, output, N: beat from requester i accepted this cycle when valid and ready are both 1.
REQ-009 Port out_data_o, output, DW: registered output data.
REQ-010 Port out_valid_o, output, 1: output beat present.
REQ-011 Port out_last_o, output, 1: output beat ends a packet.
REQ-012 Port out_src_o, output, $clog2(N): index of the requester that produced the output beat.
REQ-013 Port out_ready_i, input, 1: downstream accepts the output beat.

Function
REQ-014 The output stage SHALL be "free" in a cycle when out_valid_o=0 or out_ready_i=1.
REQ-015 The FSM SHALL have two states, IDLE and LOCKED, plus a round-robin pointer ptr (0..N-1) and an owner register.
REQ-016 In IDLE, the winner SHALL be the first i with in_valid_i[i]=1, searching ptr, ptr+1, ... and wrapping modulo N.
REQ-017 In IDLE, in_ready_o SHALL be 1 only for the winner and only when the stage is free; all other bits are 0; no winner gives all-zero.
REQ-018 In LOCKED, in_ready_o[owner] SHALL equal "stage free"; all other bits are 0, regardless of their valids.
REQ-019 On an accepted beat, the stage SHALL load data, last and source index, and set out_valid_o=1 on the next cycle (latency 1 cycle).
REQ-020 A beat accepted in IDLE with last=0 SHALL move the FSM to LOCKED with owner=winner; ptr is unchanged.
REQ-021 An accepted beat with last=1, in either state, SHALL move the FSM to IDLE and set ptr=(source+1) mod N, wrapping N-1 to 0.
REQ-022 With out_valid_o=1 and out_ready_i=1 and no new beat accepted, out_valid_o SHALL fall to 0 on the next cycle.
REQ-023 Simultaneous drain and load SHALL keep out_valid_o=1 with the new beat, sustaining 1 beat per cycle.
REQ-024 While out_valid_o=1 and out_ready_i=0, out_data_o, out_last_o and out_src_o SHALL remain stable.
REQ-025 In LOCKED, an owner with in_valid_i=0 SHALL keep the lock; gaps inside a packet never release arbitration.
REQ-026 Beats SHALL never be duplicated, dropped or reordered within one requester.

Reset
REQ-027 While rst_ni=0: out_valid_o=0, out_data_o=0, out_last_o=0, out_src_o=0, in_ready_o=0, FSM=IDLE, ptr=0, owner=0.
REQ-028 Reset asserted mid-packet SHALL discard the lock and any buffered beat; the first grant after release starts from ptr=0.
REQ-029 Outputs SHALL respond to rst_ni falling without waiting for a clk_i edge.

Verification
REQ-030 All four requesters valid with last=1 every beat, out_ready_i=1 -> out_src_o sequence 0,1,2,3,0..., one beat per cycle after 1-cycle latency.
REQ-031 Req 2 sends a 3-beat packet (last on beat 3) while req 0 is valid throughout -> out_src_o=2,2,2 then 0; in_ready_o[0]=0 during the packet.
REQ-032 out_ready_i=0 for 5 cycles with out_valid_o=1, data 0xDEADBEEF -> output held stable, in_ready_o all 0; one beat resumes per cycle after release.
REQ-033 ptr=3, only req 1 valid -> req 1 granted (wrap search); after its last beat, ptr=2.
REQ-034 Owner deasserts valid for 2 cycles mid-packet while req 3 is valid -> req 3 is not granted until the owner's last beat is accepted.
REQ-035 rst_ni pulsed low mid-packet with out_valid_o=1 -> out_valid_o=0 immediately; after release, all valid -> req 0 granted first.
